// File: rtl/alu_seq_if.sv
// alu_seq handshake bundle: operand/op request side
// and result/flag response side, each valid/ready.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result,
    output zero, neg, carry, ovf
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result,
    input  zero, neg, carry, ovf
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: one op per handshake, MUL as an
// iterative shift-add, result held until consumed.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic    clk,
  input logic    rst,
  alu_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  state_e             state_q;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q;
  logic               neg_q;
  logic               carry_q;
  logic               ovf_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcd_q;
  logic [WIDTH-1:0]   mlr_q;
  logic [SHW:0]       cnt_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     wide;
  logic [2*WIDTH-1:0] acc_d;
  logic               a_msb;
  logic               b_msb;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;

  assign a_msb = bus.a[WIDTH-1];
  assign b_msb = bus.b[WIDTH-1];

  // Next accumulator: add the shifted multiplicand when
  // the current multiplier LSB is set.
  assign acc_d = acc_q + (mlr_q[0] ? mcd_q : '0);

  // Single-cycle ops; ADD/SUB carry out of WIDTH+1 bits.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    case (bus.op)
      OP_ADD: begin
        wide    = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (a_msb == b_msb) &&
                  (wide[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        wide    = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (a_msb != b_msb) &&
                  (wide[WIDTH-1] != a_msb);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SLL: alu_res = bus.a << bus.b[SHW-1:0];
      OP_SRA: alu_res = $signed(bus.a) >>> bus.b[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  // Control FSM plus result/flag and multiplier registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
      mcd_q   <= '0;
      mlr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.op == OP_MUL) begin
              mcd_q   <= {{WIDTH{1'b0}}, bus.a};
              mlr_q   <= bus.b;
              acc_q   <= '0;
              cnt_q   <= CNT_INIT;
              state_q <= BUSY;
            end else begin
              res_q   <= alu_res;
              zero_q  <= (alu_res == '0);
              neg_q   <= alu_res[WIDTH-1];
              carry_q <= alu_c;
              ovf_q   <= alu_v;
              state_q <= DONE;
            end
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          mcd_q <= mcd_q << 1;
          mlr_q <= mlr_q >> 1;
          cnt_q <= cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            res_q   <= acc_d[WIDTH-1:0];
            zero_q  <= (acc_d[WIDTH-1:0] == '0);
            neg_q   <= acc_d[WIDTH-1];
            carry_q <= 1'b0;
            ovf_q   <= |acc_d[2*WIDTH-1:WIDTH];
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: vector table
// plus hand sequences for MUL, backpressure and reset.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
    int         lat;
  } vec_t;

  vec_t vecs [15];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.zero, bus.neg, bus.carry, bus.ovf};
  endfunction

  // Issue one op, wait for out_valid, check, drain.
  task automatic run_op(input string nm,
                        input logic [2:0] o,
                        input logic [7:0] x,
                        input logic [7:0] y,
                        input logic [7:0] er,
                        input logic [3:0] ef,
                        input int el);
    int lat;
    logic busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = ~x;
    bus.b = ~y;
    bus.op = 3'b000;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) break;
      if (bus.in_ready) busy_ok = 1'b0;
    end
    chk({nm, ".lat"}, lat, el);
    chk({nm, ".busy"}, busy_ok, 1);
    chk({nm, ".res"}, bus.result, er);
    chk({nm, ".flg"}, flags(), ef);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({nm, ".ovld"}, bus.out_valid, 0);
    chk({nm, ".rdy"}, bus.in_ready, 1);
  endtask

  initial begin
    // {op, a, b, result, {zero,neg,carry,ovf}, latency}
    vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b0101, 1};
    vecs[1]  = '{3'b001, 8'h03, 8'h05, 8'hFE, 4'b0110, 1};
    vecs[2]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001, 1};
    vecs[3]  = '{3'b111, 8'd15, 8'd17, 8'hFF, 4'b0100, 8};
    vecs[4]  = '{3'b111, 8'd16, 8'd16, 8'h00, 4'b1001, 8};
    vecs[5]  = '{3'b110, 8'h80, 8'h0B, 8'hF0, 4'b0100, 1};
    vecs[6]  = '{3'b101, 8'h01, 8'h07, 8'h80, 4'b0100, 1};
    vecs[7]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1010, 1};
    vecs[8]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1};
    vecs[9]  = '{3'b011, 8'h0F, 8'hA0, 8'hAF, 4'b0100, 1};
    vecs[10] = '{3'b100, 8'hAA, 8'hAA, 8'h00, 4'b1000, 1};
    vecs[11] = '{3'b001, 8'h05, 8'h05, 8'h00, 4'b1000, 1};
    vecs[12] = '{3'b111, 8'hFF, 8'hFF, 8'h01, 4'b0001, 8};
    vecs[13] = '{3'b000, 8'h80, 8'h80, 8'h00, 4'b1011, 1};
    vecs[14] = '{3'b110, 8'h7F, 8'h17, 8'h00, 4'b1000, 1};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.rdy", bus.in_ready, 1);
    chk("rst.ovld", bus.out_valid, 0);
    chk("rst.res", bus.result, 0);
    chk("rst.flg", flags(), 0);

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a,
             vecs[i].b, vecs[i].res, vecs[i].flg,
             vecs[i].lat);
    end

    // Backpressure: result held, new requests ignored.
    bus.op = 3'b100;
    bus.a = 8'hAA;
    bus.b = 8'h55;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.ovld", bus.out_valid, 1);
      chk("bp.res", bus.result, 8'hFF);
      chk("bp.rdy", bus.in_ready, 0);
      bus.a = 8'(i * 37 + 1);
      bus.b = 8'(i * 11 + 3);
      @(posedge clk);
      #1;
    end
    bus.a = 8'h11;
    bus.b = 8'h22;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp.drop", bus.out_valid, 0);
    chk("bp.rdy1", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp.acc", bus.out_valid, 1);
    chk("bp.res2", bus.result, 8'h33);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Reset at the 3rd BUSY edge of a MUL.
    bus.op = 3'b111;
    bus.a = 8'd15;
    bus.b = 8'd17;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rm.busy", bus.in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rm.rdy", bus.in_ready, 1);
    chk("rm.ovld", bus.out_valid, 0);
    chk("rm.res", bus.result, 0);
    chk("rm.flg", flags(), 0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid) seen = 1'b1;
      end
      chk("rm.nopulse", seen, 0);
    end
    run_op("rm.add", 3'b000, 8'h01, 8'h01,
           8'h02, 4'b0000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
